// File: rtl/stash_scan_table_mw_if.sv
// Scan/DMA port bundle for stash_scan_table_mw; master drives candidates and reads, slave is the table.
// SCAN_TABLE_STATS_EN adds the reject counter and path-full status signals.
interface stash_scan_table_mw_if #(
    parameter int ORAML    = 32,
    parameter int ORAMZ    = 4,
    parameter int SEAWidth = 7,
    parameter int Lanes    = 2,
    parameter int STAWidth = $clog2(ORAMZ * (ORAML + 1))
);
    logic                      PerAccessReset;
    logic                      ResetDone;
    logic [ORAML-1:0]          CurrentLeaf;
    logic                      CurrentLeafValid;
    logic [Lanes*ORAML-1:0]    InScanLeaf;
    logic [Lanes*SEAWidth-1:0] InScanSAddr;
    logic [Lanes-1:0]          InScanValid;
    logic [Lanes-1:0]          OutScanValid;
    logic [Lanes-1:0]          OutScanAccepted;
    logic [Lanes*SEAWidth-1:0] OutScanSAddr;
    logic [STAWidth-1:0]       InDMAAddr;
    logic                      InDMAValid;
    logic                      InDMAReady;
    logic [SEAWidth-1:0]       OutDMAAddr;
    logic                      OutDMAValid;
    logic                      OutDMALast;
`ifdef SCAN_TABLE_STATS_EN
    logic [15:0]               OutRejectCount;
    logic                      OutPathFull;
`endif

    modport master (
        output PerAccessReset, CurrentLeaf, CurrentLeafValid, InScanLeaf, InScanSAddr, InScanValid,
        output InDMAAddr, InDMAValid,
        input  ResetDone, OutScanValid, OutScanAccepted, OutScanSAddr, InDMAReady,
        input  OutDMAAddr, OutDMAValid, OutDMALast
`ifdef SCAN_TABLE_STATS_EN
        , input OutRejectCount, OutPathFull
`endif
    );

    modport slave (
        input  PerAccessReset, CurrentLeaf, CurrentLeafValid, InScanLeaf, InScanSAddr, InScanValid,
        input  InDMAAddr, InDMAValid,
        output ResetDone, OutScanValid, OutScanAccepted, OutScanSAddr, InDMAReady,
        output OutDMAAddr, OutDMAValid, OutDMALast
`ifdef SCAN_TABLE_STATS_EN
        , output OutRejectCount, OutPathFull
`endif
    );
endinterface

// File: rtl/stash_scan_table_mw.sv
// Multi-lane stash scan table: places candidates in the deepest free bucket on the path; optional SCAN_TABLE_STATS_EN stats.
// Scan results after 1+Pipelined cycles, DMA read data after 1 cycle; DMA reads are refused while any scan is in flight.
module stash_scan_table_mw #(
    parameter int ORAML     = 32,
    parameter int ORAMZ     = 4,
    parameter int SEAWidth  = 7,
    parameter int Lanes     = 2,
    parameter int Pipelined = 1,
    parameter logic [SEAWidth-1:0] SNULL = '1,
    parameter int STAWidth  = $clog2(ORAMZ * (ORAML + 1))
) (
    input  logic Clock,
    input  logic Reset,
    stash_scan_table_mw_if.slave io
);
    localparam int Levels       = ORAML + 1;
    localparam int BlocksOnPath = ORAMZ * Levels;
    localparam int CW           = $clog2(ORAMZ + 1);
    localparam int LW           = $clog2(Levels);
    localparam logic [CW-1:0] CntFull = CW'(ORAMZ);

    logic                      clr;
    logic [Lanes*ORAML-1:0]    st_leaf;
    logic [Lanes*SEAWidth-1:0] st_saddr;
    logic [Lanes-1:0]          st_vld;
    logic                      st_busy;

    logic [CW-1:0]             cnt_q [Levels];
    logic [CW-1:0]             cnt_d [Levels];
    logic [BlocksOnPath-1:0]   slot_vld_q, slot_vld_d;
    logic [SEAWidth-1:0]       tbl_q [BlocksOnPath];
    logic [SEAWidth-1:0]       tbl_d [BlocksOnPath];
    logic [Lanes-1:0]          acc;

    logic [Lanes-1:0]          out_vld_q, out_vld_d, out_acc_q, out_acc_d;
    logic [Lanes*SEAWidth-1:0] out_saddr_q, out_saddr_d;
    logic                      rst_done_q, rst_done_d;
    logic                      dma_rdy, dma_acc;
    logic                      dma_vld_q, dma_vld_d, dma_last_q, dma_last_d;
    logic [SEAWidth-1:0]       dma_addr_q, dma_addr_d;

    assign clr = Reset | io.PerAccessReset;

    generate
        if (Pipelined != 0) begin : g_pipe
            logic [Lanes*ORAML-1:0]    s0_leaf_q, s0_leaf_d;
            logic [Lanes*SEAWidth-1:0] s0_saddr_q, s0_saddr_d;
            logic [Lanes-1:0]          s0_vld_q, s0_vld_d;

            always_comb begin
                s0_leaf_d  = io.InScanLeaf;
                s0_saddr_d = io.InScanSAddr;
                s0_vld_d   = io.InScanValid;
            end

            always_ff @(posedge Clock) begin
                s0_leaf_q  <= s0_leaf_d;
                s0_saddr_q <= s0_saddr_d;
                if (clr) s0_vld_q <= '0;
                else     s0_vld_q <= s0_vld_d;
            end

            assign st_leaf  = s0_leaf_q;
            assign st_saddr = s0_saddr_q;
            assign st_vld   = s0_vld_q;
            assign st_busy  = |s0_vld_q;
        end else begin : g_nopipe
            assign st_leaf  = io.InScanLeaf;
            assign st_saddr = io.InScanSAddr;
            assign st_vld   = io.InScanValid;
            assign st_busy  = 1'b0;
        end
    endgenerate

    // Lanes resolve in order against the running counts so a lower lane's placement is visible to higher lanes.
    always_comb begin
        logic [ORAML-1:0]    x;
        int                  d;
        logic                found;
        logic [LW-1:0]       lvl;
        logic [STAWidth-1:0] idx;
        cnt_d      = cnt_q;
        slot_vld_d = slot_vld_q;
        tbl_d      = tbl_q;
        acc        = '0;
        x          = '0;
        d          = 0;
        found      = 1'b0;
        lvl        = '0;
        idx        = '0;
        for (int l = 0; l < Lanes; l++) begin
            if (st_vld[l] && io.CurrentLeafValid) begin
                x = st_leaf[l*ORAML +: ORAML] ^ io.CurrentLeaf;
                d = ORAML;
                for (int k = ORAML - 1; k >= 0; k--) begin
                    if (x[k]) d = k;
                end
                found = 1'b0;
                for (int v = 0; v < Levels; v++) begin
                    if (v <= d && cnt_d[v] != CntFull) begin
                        found = 1'b1;
                        lvl   = LW'(v);
                    end
                end
                if (found) begin
                    idx              = STAWidth'(int'(lvl) * ORAMZ + int'(cnt_d[lvl]));
                    tbl_d[idx]       = st_saddr[l*SEAWidth +: SEAWidth];
                    slot_vld_d[idx]  = 1'b1;
                    cnt_d[lvl]       = cnt_d[lvl] + CW'(1);
                    acc[l]           = 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_vld_d   = st_vld;
        out_acc_d   = acc;
        out_saddr_d = st_saddr;
        rst_done_d  = 1'b1;
    end

    assign dma_rdy = rst_done_q & ~st_busy & ~(|out_vld_q) & ~(|io.InScanValid);
    assign dma_acc = io.InDMAValid & dma_rdy;

    always_comb begin
        dma_vld_d  = dma_acc;
        dma_addr_d = dma_addr_q;
        dma_last_d = 1'b0;
        if (dma_acc) begin
            dma_addr_d = SNULL;
            if (int'(io.InDMAAddr) < BlocksOnPath) begin
                if (slot_vld_q[io.InDMAAddr]) dma_addr_d = tbl_q[io.InDMAAddr];
                dma_last_d = (int'(io.InDMAAddr) == BlocksOnPath - 1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (clr) begin
            for (int i = 0; i < Levels; i++) cnt_q[i] <= '0;
            slot_vld_q  <= '0;
            out_vld_q   <= '0;
            out_acc_q   <= '0;
            out_saddr_q <= '0;
            rst_done_q  <= 1'b0;
            dma_vld_q   <= 1'b0;
            dma_addr_q  <= SNULL;
            dma_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            slot_vld_q  <= slot_vld_d;
            out_vld_q   <= out_vld_d;
            out_acc_q   <= out_acc_d;
            out_saddr_q <= out_saddr_d;
            rst_done_q  <= rst_done_d;
            dma_vld_q   <= dma_vld_d;
            dma_addr_q  <= dma_addr_d;
            dma_last_q  <= dma_last_d;
        end
    end

    // Slot contents are qualified by slot_vld_q, so the data array never needs clearing.
    always_ff @(posedge Clock) begin
        tbl_q <= tbl_d;
    end

    assign io.ResetDone       = rst_done_q;
    assign io.OutScanValid    = out_vld_q;
    assign io.OutScanAccepted = out_acc_q;
    assign io.OutScanSAddr    = out_saddr_q;
    assign io.InDMAReady      = dma_rdy;
    assign io.OutDMAAddr      = dma_addr_q;
    assign io.OutDMAValid     = dma_vld_q;
    assign io.OutDMALast      = dma_last_q;

`ifdef SCAN_TABLE_STATS_EN
    logic [15:0] rej_cnt_q, rej_cnt_d;
    logic        path_full;

    always_comb begin
        logic [16:0] sum;
        sum = {1'b0, rej_cnt_q};
        for (int l = 0; l < Lanes; l++) begin
            if (st_vld[l] && !acc[l]) sum = sum + 17'd1;
        end
        rej_cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_comb begin
        path_full = 1'b1;
        for (int i = 0; i < Levels; i++) begin
            if (cnt_q[i] != CntFull) path_full = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (clr) rej_cnt_q <= '0;
        else     rej_cnt_q <= rej_cnt_d;
    end

    assign io.OutRejectCount = rej_cnt_q;
    assign io.OutPathFull    = path_full;
`endif
endmodule

// File: doc/stash_scan_table_mw.md
Name: stash_scan_table_mw

Overview:
- Multi-lane successor to the stash scan table.
- Accepts up to Lanes stash-entry candidates per cycle.
- Greedily assigns each candidate to the deepest bucket on the current path that has a free slot, and records its stash address in a register-based path table.
- Path writeback logic reads the table back in slot order.
- Per-slot valid bits replace the per-access SNULL fill walk, so per-access reset takes one cycle instead of BlocksOnPath cycles.

Parameters:
ORAML, 32, leaf width; the path has ORAML+1 levels, level 0 is the root.
ORAMZ, 4, slots per bucket.
SEAWidth, 7, stash entry address width.
Lanes, 2, scan candidates per cycle (1..4).
Pipelined, 1, extra input register stage (0 or 1).
SNULL, all-ones, value returned for an empty slot.

Ports:
Clock  in  1  system clock.
Reset  in  1  synchronous, active-high.
PerAccessReset  in  1  synchronous, active-high; clears per-access state.
ResetDone  out  1  table ready for a new access.
CurrentLeaf  in  ORAML  leaf of the current access.
CurrentLeafValid  in  1  CurrentLeaf is stable.
InScanLeaf  in  Lanes*ORAML  per-lane block leaf; lane 0 is in the LSBs.
InScanSAddr  in  Lanes*SEAWidth  per-lane stash address.
InScanValid  in  Lanes  per-lane candidate valid.
OutScanValid  out  Lanes  delayed InScanValid.
OutScanAccepted  out  Lanes  candidate placed on the path.
OutScanSAddr  out  Lanes*SEAWidth  delayed InScanSAddr.
InDMAAddr  in  STAWidth  slot index, STAWidth = log2(ORAMZ*(ORAML+1)).
InDMAValid  in  1  read request.
InDMAReady  out  1  read request can be accepted.
OutDMAAddr  out  SEAWidth  slot contents, or SNULL if the slot is empty.
OutDMAValid  out  1  OutDMAAddr is valid.
OutDMALast  out  1  this is the last slot, BlocksOnPath-1.

Behaviour:
- Clock/reset: single clock Clock; synchronous active-high Reset. Reset and PerAccessReset both clear all bucket counts, all slot-valid bits and the pipeline valids. Table data is not cleared.
- Reset values of outputs: ResetDone=0; OutScanValid=0; OutScanAccepted=0; OutScanSAddr=0; OutDMAValid=0; OutDMAAddr=SNULL; OutDMALast=0; InDMAReady=0.
- ResetDone timing: rises exactly 1 cycle after Reset/PerAccessReset deasserts and stays high until the next reset.
- Level match:
  - X = InScanLeaf[lane] ^ CurrentLeaf.
  - Leaf bit k corresponds to path level k+1.
  - Eligible levels are 0..d, where d = number of trailing zeros of X (d = ORAML when X = 0).
- Lane resolution (combinational within one stage, lanes in ascending order):
  - Each lane sees counts already incremented by lower lanes in the same cycle.
  - A lane picks the deepest eligible level with count < ORAMZ.
  - An accepted lane at level v writes its SAddr into slot v*ORAMZ + count[v], sets that slot's valid bit, and increments count[v].
  - If no eligible level has space, the lane is rejected.
  - If CurrentLeafValid=0, every lane is rejected.
- Latency:
  - Scan outputs appear 1+Pipelined cycles after the inputs.
  - Counts and table are updated at the same edge as the outputs.
  - A candidate in cycle t+1 always sees the updates from cycle t. No hazard exists, because counts are read at the decision stage.
- Saturation: a count never exceeds ORAMZ; a full level is skipped.
- DMA read port:
  - InDMAReady = ResetDone & no scan valid in any pipeline stage & ~InScanValid.
  - A request is accepted when InDMAValid & InDMAReady.
  - OutDMAValid pulses 1 cycle after acceptance with the slot contents (SNULL if the valid bit is clear).
  - OutDMALast accompanies OutDMAValid when the accepted address was BlocksOnPath-1.
  - Out-of-range addresses return SNULL with OutDMALast=0.
  - A request while InDMAReady=0 is dropped.
- Reset mid-operation: in-flight scan results are discarded, with no OutScanValid pulse after the reset edge. A pending DMA read is cancelled.

Optional Feature:
- Macro: SCAN_TABLE_STATS_EN.
- Enabled:
  - Adds output OutRejectCount (16 bits), which counts rejected valid lanes per access, saturates at 0xFFFF and clears on Reset/PerAccessReset.
  - Adds output OutPathFull (1 bit), which is high when every level count equals ORAMZ.
- Disabled: neither port exists and no logic is added.

Test Plan:
- ORAML=3, ORAMZ=2, Lanes=2, Pipelined=1. CurrentLeaf=3'b101; lane0 leaf 101 SAddr 5, lane1 leaf 101 SAddr 6 → both accepted after 2 cycles into slots 6 and 7 (level 3). DMA read of 6 → 5; read of 7 → 6 with OutDMALast=1.
- Same cycle, three leaf-101 candidates across two cycles (SAddr 1,2 then 3) → third placed in level 2, slot 4. Lane ordering is respected: lane0 takes slot 6 before lane1.
- Lane leaf 3'b100 vs 101 (d=0) with the root count at 2 → rejected, OutScanAccepted=0, table unchanged. With the macro enabled, OutRejectCount=1.
- PerAccessReset after a filled path → ResetDone low 1 cycle. Reads of all 8 slots return SNULL; counts are back to 0.
- InDMAValid asserted while InScanValid=1 → InDMAReady=0, no OutDMAValid. Retried after the pipeline drains → data returned 1 cycle later.
- Reset asserted the cycle after a scan input with Pipelined=1 → no OutScanValid pulse; slot valid bits remain clear.
